// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with one-word blocks.
// A lookup is combinational, so a hit costs no cycles. A miss moves the
// FSM to MISS, which forwards the request to memory until iwait drops.
// The returned word is written into the indexed frame, and the request
// hits in IDLE on the following cycle.
module icache_dm #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  typedef enum logic {IDLE, MISS} state_t;

  state_t state_reg;
  state_t state_next;

  // Frame storage. Only the valid bits need a reset.
  logic [SETS-1:0]  valid_reg;
  logic [SETS-1:0]  valid_next;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lookup_hit;
  logic             fill_en;

  // Byte-offset bits do not select anything in a word-organised cache.
  logic unused_lsbs;
  assign unused_lsbs = ^imemaddr[1:0];

  assign req_idx = imemaddr[IDX_W+1:2];
  assign req_tag = imemaddr[31:IDX_W+2];

  assign lookup_hit = imemREN & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);

  // The fill uses the address that is current when memory completes, so a
  // redirect during MISS lands in the frame that belongs to the new address.
  assign fill_en = (state_reg == MISS) & imemREN & ~iwait;

  // Per-frame valid update. A fill sets the bit and nothing clears it
  // except reset.
  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_valid
      assign valid_next[gi] = valid_reg[gi] | (fill_en & (req_idx == IDX_W'(gi)));
    end
  endgenerate

  // Valid bits and FSM state. Async reset invalidates every frame and
  // abandons any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_reg <= '0;
      state_reg <= IDLE;
    end else begin
      valid_reg <= valid_next;
      state_reg <= state_next;
    end
  end

  // Tag/data write on fill. A conflicting frame is simply overwritten.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= iload;
    end
  end

  // Next-state and output decode. ihit is held low throughout MISS because
  // the fill data is not bypassed.
  always_comb begin
    state_next = state_reg;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    case (state_reg)
      IDLE: begin
        ihit = lookup_hit;
        if (lookup_hit) begin
          imemload = data_mem[req_idx];
        end
        if (imemREN && !lookup_hit) begin
          state_next = MISS;
        end
      end
      MISS: begin
        iREN  = imemREN;
        iaddr = {imemaddr[31:2], 2'b00};
        if (!imemREN || !iwait) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed stimulus for icache_dm. A behavioural model keeps
// the full word address cached in each frame plus one "request outstanding"
// flag. It is compared against the DUT on every falling edge. Literal checks
// pin down latency and data values.
module tb_icache_dm;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload = 32'h0;
  logic        iwait = 1'b1;

  int errors = 0;
  int checks = 0;

  icache_dm #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_valid [SETS];
  bit [29:0] m_word  [SETS];
  bit [31:0] m_data  [SETS];
  bit        m_pending;

  function automatic bit m_lookup(input logic [31:0] a);
    int i;
    i = int'(a[31:2]) % SETS;
    return m_valid[i] && (m_word[i] == a[31:2]);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
      m_pending <= 1'b0;
    end else if (!m_pending) begin
      if (imemREN && !m_lookup(imemaddr)) m_pending <= 1'b1;
    end else if (!imemREN) begin
      m_pending <= 1'b0;
    end else if (!iwait) begin
      m_valid[int'(imemaddr[31:2]) % SETS] <= 1'b1;
      m_word[int'(imemaddr[31:2]) % SETS]  <= imemaddr[31:2];
      m_data[int'(imemaddr[31:2]) % SETS]  <= iload;
      m_pending <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    logic        e_hit;
    logic [31:0] e_ld;
    e_hit = imemREN && !m_pending && m_lookup(imemaddr);
    e_ld  = e_hit ? m_data[int'(imemaddr[31:2]) % SETS] : 32'h0;
    chk("mdl_ihit", {31'h0, ihit}, {31'h0, e_hit});
    chk("mdl_imemload", imemload, e_ld);
    chk("mdl_iREN", {31'h0, iREN}, {31'h0, m_pending && imemREN});
    chk("mdl_iaddr", iaddr, m_pending ? {imemaddr[31:2], 2'b00} : 32'h0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Request addr; memory answers after nwait busy cycles. Returns the number
  // of cycles from the request to ihit and the number of iREN cycles seen.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data,
                      input int nwait, output int lat, output int ren_cnt);
    int c;
    lat = -1;
    ren_cnt = 0;
    tick();
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; iload = data;
    settle();
    if (ihit) lat = 0;
    for (c = 1; c < 40 && lat < 0; c++) begin
      tick();
      iwait = (c <= nwait) ? 1'b1 : 1'b0;
      settle();
      if (iREN) ren_cnt++;
      if (ihit) lat = c;
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL fill_timeout: addr %h got no ihit expected ihit within 40 cycles", addr);
    end
    iwait = 1'b1;
  endtask

  initial begin
    int lat, rc;

    // Reset state
    #2;
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_iREN", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    tick();
    tick();
    nRST = 1'b1;

    // Cold miss with three wait cycles
    fill(32'h0000_0000, 32'h2000_0001, 3, lat, rc);
    chk("cold_latency", lat, 5);
    chk("cold_iren_cycles", rc, 4);
    chk("cold_data", imemload, 32'h2000_0001);
    chk("cold_iren_at_hit", {31'h0, iREN}, 32'h0);
    $display("txn cold_miss addr=00000000 lat=%0d iren=%0d", lat, rc);

    // Repeat hit
    tick();
    imemaddr = 32'h0;
    settle();
    chk("rep_ihit", {31'h0, ihit}, 32'h1);
    chk("rep_iREN", {31'h0, iREN}, 32'h0);
    chk("rep_data", imemload, 32'h2000_0001);
    $display("txn repeat_hit addr=00000000 data=%h", imemload);

    // Conflict eviction
    fill(32'h0000_0004, 32'hAAAA_0000, 0, lat, rc);
    chk("fill4_latency", lat, 2);
    fill(32'h0000_0044, 32'hBBBB_0000, 0, lat, rc);
    chk("fill44_data", imemload, 32'hBBBB_0000);
    tick();
    imemaddr = 32'h0000_0004;
    settle();
    chk("evict_ihit", {31'h0, ihit}, 32'h0);
    tick();
    settle();
    chk("evict_iREN", {31'h0, iREN}, 32'h1);
    chk("evict_iaddr", iaddr, 32'h0000_0004);
    tick();
    imemREN = 1'b0;
    settle();
    $display("txn conflict_evict addr=00000004 missed after 00000044 fill");

    // Abort
    tick();
    imemREN = 1'b1; imemaddr = 32'h0000_0010; iwait = 1'b1;
    tick();
    tick();
    tick();
    imemREN = 1'b0;
    settle();
    chk("abort_iREN", {31'h0, iREN}, 32'h0);
    tick();
    imemREN = 1'b1;
    settle();
    chk("abort_rereq_ihit", {31'h0, ihit}, 32'h0);
    tick();
    settle();
    chk("abort_rereq_iREN", {31'h0, iREN}, 32'h1);
    tick();
    imemREN = 1'b0;
    $display("txn abort addr=00000010");

    // Reset mid-miss
    tick();
    imemREN = 1'b1; imemaddr = 32'h0000_0020; iwait = 1'b1;
    tick();
    settle();
    chk("rstmiss_iREN_before", {31'h0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    chk("rstmiss_iREN_now", {31'h0, iREN}, 32'h0);
    chk("rstmiss_iaddr_now", iaddr, 32'h0);
    tick();
    nRST = 1'b1;
    imemaddr = 32'h0;
    settle();
    chk("rstmiss_old_line_gone", {31'h0, ihit}, 32'h0);
    tick();
    imemREN = 1'b0;
    $display("txn reset_mid_miss addr=00000020");

    // Low-order address bits ignored
    fill(32'h0000_0008, 32'h1234_5678, 1, lat, rc);
    chk("lsb_fill_latency", lat, 3);
    tick();
    imemaddr = 32'h0000_000B;
    settle();
    chk("lsb_ihit", {31'h0, ihit}, 32'h1);
    chk("lsb_data", imemload, 32'h1234_5678);
    $display("txn low_bits addr=0000000b data=%h", imemload);

    // Address wrap
    fill(32'hFFFF_FFFC, 32'hCAFE_F00D, 2, lat, rc);
    chk("wrap_latency", lat, 4);
    chk("wrap_data", imemload, 32'hCAFE_F00D);
    $display("txn wrap addr=fffffffc lat=%0d", lat);

    // Redirect during MISS: the fill follows the new address
    tick();
    imemaddr = 32'h0000_0100; iwait = 1'b1;
    tick();
    imemaddr = 32'h0000_0200; iwait = 1'b0; iload = 32'h0BAD_CAFE;
    settle();
    chk("redir_iaddr", iaddr, 32'h0000_0200);
    tick();
    iwait = 1'b1;
    settle();
    chk("redir_ihit", {31'h0, ihit}, 32'h1);
    chk("redir_data", imemload, 32'h0BAD_CAFE);
    tick();
    imemaddr = 32'h0000_0100;
    settle();
    chk("redir_old_miss", {31'h0, ihit}, 32'h0);
    tick();
    imemREN = 1'b0;
    $display("txn redirect from=00000100 to=00000200");

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
